fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 41 ++++
 rtl/fetch_unit_if.sv | 46 ++++
 rtl/fetch_unit_npc_logic.sv | 28 ++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU types for the fetch stage: word type, fetch FSM states,
// and the opcode/funct encodings exposed on the decoded instruction fields.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IFETCH = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDIU = 6'h09,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'h00,
        JR   = 6'h08,
        ADDU = 6'h21,
        SUBU = 6'h23,
        SLT  = 6'h2A
    } funct_t;

    // Sequential PC increment (one 32-bit instruction word).
    localparam word_t PC_STEP = 32'd4;

    // J/JAL target: keep the 256 MB region of PC+4, splice in the word index.
    function automatic word_t jumpTarget(logic [3:0] region, logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory/control handshake signals.
// Optional InstrCount exists only when FETCH_INSTR_COUNT_EN is defined.
interface fetch_unit_if;
    import cpu_types_pkg::*;

    logic    iHit;
    word_t   iload;
    logic    dHit;
    logic    dMemRe;
    logic    dMemWr;
    logic    Halt;
    logic    PcSrc;
    logic    JType;
    logic    JReg;
    word_t   ImmExt;
    word_t   RegTarget;

    logic    iMemRe;
    word_t   iMemAddr;
    word_t   Instr;
    opcode_t InstrOp;
    funct_t  InstrFunc;
    word_t   PcPlus4;
    logic    PcCountEn;
    logic    Halted;
`ifdef FETCH_INSTR_COUNT_EN
    word_t   InstrCount;
`endif

    modport fu (
        input  iHit, iload, dHit, dMemRe, dMemWr, Halt, PcSrc, JType, JReg, ImmExt, RegTarget,
        output iMemRe, iMemAddr, Instr, InstrOp, InstrFunc, PcPlus4, PcCountEn, Halted
`ifdef FETCH_INSTR_COUNT_EN
        , output InstrCount
`endif
    );

    modport tb (
        output iHit, iload, dHit, dMemRe, dMemWr, Halt, PcSrc, JType, JReg, ImmExt, RegTarget,
        input  iMemRe, iMemAddr, Instr, InstrOp, InstrFunc, PcPlus4, PcCountEn, Halted
`ifdef FETCH_INSTR_COUNT_EN
        , input InstrCount
`endif
    );

endinterface

// File: rtl/fetch_unit_npc_logic.sv
// Combinational next-PC selection: JR > J/JAL > taken branch > sequential.
module npc_logic
    import cpu_types_pkg::*;
(
    input  word_t       pcPlus4,
    input  logic [25:0] jumpIndex,
    input  word_t       immExt,
    input  word_t       regTarget,
    input  logic        pcSrc,
    input  logic        jType,
    input  logic        jReg,
    output word_t       nextPc
);

    // Priority mux over the four PC sources; all sums wrap modulo 2^32.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves nextPc unassigned (which would infer a latch).
        nextPc = pcPlus4;
        if (jReg) begin
            nextPc = regTarget;
        end else if (jType) begin
            nextPc = jumpTarget(pcPlus4[31:28], jumpIndex);
        end else if (pcSrc) begin
            nextPc = pcPlus4 + (immExt << 2);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IFETCH/EXEC/HALTED sequencer owning PC and the
// latched instruction. Define FETCH_INSTR_COUNT_EN to add the InstrCount
// retired-instruction counter output.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic     CLK,
    input  logic     nRST,
    fetch_unit_if.fu bus
);

    fetch_state_t state;
    word_t        pc;
    word_t        instr;
    word_t        pcPlus4;
    word_t        nextPc;
    logic         iMemRe;
    logic         pcCountEn;
    logic         halted;
    logic         dataPending;
    logic         advance;

    assign pcPlus4     = pc + PC_STEP;
    assign dataPending = bus.dMemRe | bus.dMemWr;
    // PC moves only when executing a non-halt instruction whose data access (if any) completes.
    assign advance     = (state == EXEC) && !bus.Halt && (!dataPending || bus.dHit);

    npc_logic npcLogic (
        .pcPlus4   (pcPlus4),
        .jumpIndex (instr[25:0]),
        .immExt    (bus.ImmExt),
        .regTarget (bus.RegTarget),
        .pcSrc     (bus.PcSrc),
        .jType     (bus.JType),
        .jReg      (bus.JReg),
        .nextPc    (nextPc)
    );

    // Fetch sequencer with registered iMemRe/PcCountEn/Halted; reset abandons any pending access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IFETCH;
            pc        <= PC_INIT;
            instr     <= '0;
            iMemRe    <= 1'b1;
            pcCountEn <= 1'b0;
            halted    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, matching flop behaviour.
            pcCountEn <= 1'b0;
            case (state)
                IFETCH: begin
                    if (bus.iHit) begin
                        instr  <= bus.iload;
                        state  <= EXEC;
                        iMemRe <= 1'b0;
                    end
                end
                EXEC: begin
                    if (bus.Halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                        iMemRe <= 1'b0;
                    end else if (advance) begin
                        pc        <= nextPc;
                        pcCountEn <= 1'b1;
                        state     <= IFETCH;
                        iMemRe    <= 1'b1;
                    end
                end
                HALTED: begin
                    iMemRe <= 1'b0;
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

`ifdef FETCH_INSTR_COUNT_EN
    word_t instrCount;

    // Count each PC advance; frozen in HALTED because advance never fires there.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instrCount <= '0;
        end else if (advance) begin
            instrCount <= instrCount + 32'd1;
        end
    end

    assign bus.InstrCount = instrCount;
`endif

    assign bus.iMemRe    = iMemRe;
    assign bus.iMemAddr  = pc;
    assign bus.Instr     = instr;
    assign bus.InstrOp   = opcode_t'(instr[31:26]);
    assign bus.InstrFunc = funct_t'(instr[5:0]);
    assign bus.PcPlus4   = pcPlus4;
    assign bus.PcCountEn = pcCountEn;
    assign bus.Halted    = halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// reset/halt sequences, and randomized stimulus against a behavioural model.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT   = 32'h0000_0000;
    localparam word_t I_ADDU    = 32'h0022_1821;
    localparam word_t I_JR      = 32'h03E0_0008;
    localparam word_t I_BEQBACK = 32'h1000_FFFF;
    localparam word_t I_BEQFWD  = 32'h1000_0003;
    localparam word_t I_J40     = 32'h0800_0040;
    localparam word_t I_J80     = 32'h0800_0080;
    localparam word_t I_LW      = 32'h8C22_0000;
    localparam word_t I_SW      = 32'hAC22_0004;
    localparam word_t I_HALT    = 32'hFC00_0000;
    localparam word_t I_JUNK    = 32'hDEAD_BEEF;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;

    fetch_unit_if bus ();

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK  (clk),
        .nRST (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  iHit;
        word_t iload;
        logic  dMemRe;
        logic  dMemWr;
        logic  dHit;
        logic  pcSrc;
        logic  jType;
        logic  jReg;
        word_t immExt;
        word_t regTarget;
        word_t expAddr;
        logic  expRe;
        logic  expCen;
        word_t expInstr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iHit, word_t iload, logic dRe, logic dWr, logic dHit,
                                logic pcSrc, logic jType, logic jReg, word_t imm, word_t rt,
                                word_t eAddr, logic eRe, logic eCen, word_t eInstr);
        vec_t v;
        v.iHit = iHit;   v.iload = iload;  v.dMemRe = dRe;  v.dMemWr = dWr;  v.dHit = dHit;
        v.pcSrc = pcSrc; v.jType = jType;  v.jReg = jReg;   v.immExt = imm;  v.regTarget = rt;
        v.expAddr = eAddr; v.expRe = eRe;  v.expCen = eCen; v.expInstr = eInstr;
        return v;
    endfunction

    task automatic check(string name, word_t act, word_t exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutputs(string tag, word_t eAddr, logic eRe, logic eCen,
                                logic eHalted, word_t eInstr);
        word_t e = eInstr;
        check({tag, ".iMemAddr"},  bus.iMemAddr, eAddr);
        check({tag, ".iMemRe"},    32'(bus.iMemRe), 32'(eRe));
        check({tag, ".PcCountEn"}, 32'(bus.PcCountEn), 32'(eCen));
        check({tag, ".Halted"},    32'(bus.Halted), 32'(eHalted));
        check({tag, ".Instr"},     bus.Instr, e);
        check({tag, ".InstrOp"},   32'(bus.InstrOp), 32'(e[31:26]));
        check({tag, ".InstrFunc"}, 32'(bus.InstrFunc), 32'(e[5:0]));
        check({tag, ".PcPlus4"},   bus.PcPlus4, eAddr + 32'd4);
    endtask

    task automatic setIdle();
        bus.iHit = 1'b0;  bus.iload = '0;  bus.dHit = 1'b0;  bus.dMemRe = 1'b0;
        bus.dMemWr = 1'b0; bus.Halt = 1'b0; bus.PcSrc = 1'b0; bus.JType = 1'b0;
        bus.JReg = 1'b0;  bus.ImmExt = '0; bus.RegTarget = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        #2;
        setIdle();
        rstN = 1'b1;
    endtask

    // Behavioural next-PC: priority rules written with plain arithmetic.
    function automatic word_t modelNext(word_t pc, word_t ins, logic jr, logic jt, logic br,
                                        word_t imm, word_t rt);
        word_t p4 = pc + 32'd4;
        if (jr) return rt;
        if (jt) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (br) return p4 + imm * 32'd4;
        return p4;
    endfunction

    word_t mPc;
    word_t mInstr;
    logic  mAwaitingFetch;
    logic  mHalted;
    logic  mPulse;
    word_t mCount;
    int    haltedFor;

    initial begin
        setIdle();

        // ---- Reset values while nRST is held low, then first cycle after release.
        #12;
        checkOutputs("reset", PC_INIT, 1'b1, 1'b0, 1'b0, 32'h0);
        rstN = 1'b1;
        #1;
        check("release.iMemRe", 32'(bus.iMemRe), 32'd1);

        // ---- Directed vector table, one row per clock from reset.
        vecs.push_back(mk(0, 0,         0,0,0, 0,0,0, 0, 0,            32'h0,   1,0, 32'h0));
        vecs.push_back(mk(0, 0,         0,0,0, 0,0,0, 0, 0,            32'h0,   1,0, 32'h0));
        vecs.push_back(mk(1, I_ADDU,    0,0,0, 0,0,0, 0, 0,            32'h0,   0,0, I_ADDU));
        vecs.push_back(mk(0, 0,         0,0,0, 0,0,0, 0, 0,            32'h4,   1,1, I_ADDU));
        vecs.push_back(mk(1, I_JR,      0,0,0, 0,0,0, 0, 0,            32'h4,   0,0, I_JR));
        vecs.push_back(mk(0, 0,         0,0,0, 0,0,1, 0, 32'h10,       32'h10,  1,1, I_JR));
        vecs.push_back(mk(1, I_BEQBACK, 0,0,0, 0,0,0, 0, 0,            32'h10,  0,0, I_BEQBACK));
        vecs.push_back(mk(0, 0,         0,0,0, 1,0,0, 32'hFFFF_FFFF, 0,32'h10,  1,1, I_BEQBACK));
        vecs.push_back(mk(1, I_BEQBACK, 0,0,0, 0,0,0, 0, 0,            32'h10,  0,0, I_BEQBACK));
        vecs.push_back(mk(0, 0,         0,0,0, 1,0,1, 32'hFFFF_FFFF, 32'h200, 32'h200, 1,1, I_BEQBACK));
        vecs.push_back(mk(1, I_JR,      0,0,0, 0,0,0, 0, 0,            32'h200, 0,0, I_JR));
        vecs.push_back(mk(0, 0,         0,0,0, 0,0,1, 0, 32'h100,      32'h100, 1,1, I_JR));
        vecs.push_back(mk(1, I_J40,     0,0,0, 0,0,0, 0, 0,            32'h100, 0,0, I_J40));
        vecs.push_back(mk(0, 0,         0,0,0, 0,1,0, 0, 0,            32'h100, 1,1, I_J40));
        vecs.push_back(mk(1, I_J80,     0,0,0, 0,0,0, 0, 0,            32'h100, 0,0, I_J80));
        vecs.push_back(mk(0, 0,         0,0,0, 1,1,0, 32'd5, 0,        32'h200, 1,1, I_J80));
        vecs.push_back(mk(1, I_LW,      0,0,0, 0,0,0, 0, 0,            32'h200, 0,0, I_LW));
        vecs.push_back(mk(0, 0,         1,0,0, 0,0,0, 0, 0,            32'h200, 0,0, I_LW));
        vecs.push_back(mk(1, I_JUNK,    1,0,0, 0,0,0, 0, 0,            32'h200, 0,0, I_LW));
        vecs.push_back(mk(0, 0,         1,0,0, 0,0,0, 0, 0,            32'h200, 0,0, I_LW));
        vecs.push_back(mk(0, 0,         1,0,1, 0,0,0, 0, 0,            32'h204, 1,1, I_LW));
        vecs.push_back(mk(0, 0,         1,0,1, 0,0,0, 0, 0,            32'h204, 1,0, I_LW));
        vecs.push_back(mk(1, I_SW,      0,0,0, 0,0,0, 0, 0,            32'h204, 0,0, I_SW));
        vecs.push_back(mk(0, 0,         0,1,0, 0,0,0, 0, 0,            32'h204, 0,0, I_SW));
        vecs.push_back(mk(0, 0,         0,1,1, 0,0,0, 0, 0,            32'h208, 1,1, I_SW));
        vecs.push_back(mk(1, I_JR,      0,0,0, 0,0,0, 0, 0,            32'h208, 0,0, I_JR));
        vecs.push_back(mk(0, 0,         0,0,0, 0,0,1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,1, I_JR));
        vecs.push_back(mk(1, I_ADDU,    0,0,0, 0,0,0, 0, 0,            32'hFFFF_FFFC, 0,0, I_ADDU));
        vecs.push_back(mk(0, 0,         0,0,0, 0,0,0, 0, 0,            32'h0,   1,1, I_ADDU));
        vecs.push_back(mk(1, I_BEQFWD,  0,0,0, 0,0,0, 0, 0,            32'h0,   0,0, I_BEQFWD));
        vecs.push_back(mk(0, 0,         0,0,0, 1,0,0, 32'd3, 0,        32'h10,  1,1, I_BEQFWD));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.iHit = vecs[i].iHit;     bus.iload = vecs[i].iload;
            bus.dMemRe = vecs[i].dMemRe; bus.dMemWr = vecs[i].dMemWr; bus.dHit = vecs[i].dHit;
            bus.PcSrc = vecs[i].pcSrc;   bus.JType = vecs[i].jType;   bus.JReg = vecs[i].jReg;
            bus.ImmExt = vecs[i].immExt; bus.RegTarget = vecs[i].regTarget;
            step();
            checkOutputs($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expRe,
                         vecs[i].expCen, 1'b0, vecs[i].expInstr);
        end
        setIdle();

        // ---- Reset in the middle of a pending load: access abandoned, no PC advance.
        bus.iHit = 1'b1; bus.iload = I_LW;
        step();
        setIdle();
        bus.dMemRe = 1'b1;
        step();
        checkOutputs("lwWait", 32'h10, 1'b0, 1'b0, 1'b0, I_LW);
        #3;
        rstN = 1'b0;
        #1;
        checkOutputs("midReset", PC_INIT, 1'b1, 1'b0, 1'b0, 32'h0);
        rstN = 1'b1;
        bus.dHit = 1'b1;
        step();
        checkOutputs("afterReset", PC_INIT, 1'b1, 1'b0, 1'b0, 32'h0);
        setIdle();

        // ---- Two instructions then HALT at 0x8: sticky halt, everything frozen.
        doReset();
        for (int k = 0; k < 2; k++) begin
            bus.iHit = 1'b1; bus.iload = I_ADDU;
            step();
            setIdle();
            step();
        end
        checkOutputs("preHalt", 32'h8, 1'b1, 1'b1, 1'b0, I_ADDU);
        bus.iHit = 1'b1; bus.iload = I_HALT;
        step();
        setIdle();
        bus.Halt = 1'b1;
        step();
        checkOutputs("halt", 32'h8, 1'b0, 1'b0, 1'b1, I_HALT);
        for (int k = 0; k < 12; k++) begin
            bus.iHit = 1'($urandom_range(0, 1)); bus.iload = $urandom();
            bus.dHit = 1'($urandom_range(0, 1)); bus.dMemRe = 1'($urandom_range(0, 1));
            bus.Halt = 1'($urandom_range(0, 1)); bus.PcSrc = 1'b1; bus.JReg = 1'($urandom_range(0, 1));
            bus.RegTarget = $urandom();
            step();
            checkOutputs($sformatf("halted%0d", k), 32'h8, 1'b0, 1'b0, 1'b1, I_HALT);
        end
`ifdef FETCH_INSTR_COUNT_EN
        check("haltCount", bus.InstrCount, 32'd2);
`endif
        setIdle();

        // ---- Randomized stimulus against the behavioural model.
        haltedFor = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 80 == 0 || haltedFor > 3) begin
                doReset();
                mPc = PC_INIT; mInstr = '0; mAwaitingFetch = 1'b1; mHalted = 1'b0; mCount = '0;
                haltedFor = 0;
            end
            bus.iHit      = 1'($urandom_range(0, 1));
            bus.iload     = $urandom();
            bus.dMemRe    = ($urandom_range(0, 3) == 0);
            bus.dMemWr    = ($urandom_range(0, 3) == 0);
            bus.dHit      = 1'($urandom_range(0, 1));
            bus.Halt      = ($urandom_range(0, 29) == 0);
            bus.PcSrc     = ($urandom_range(0, 2) == 0);
            bus.JType     = ($urandom_range(0, 3) == 0);
            bus.JReg      = ($urandom_range(0, 3) == 0);
            bus.ImmExt    = word_t'($urandom_range(0, 15)) - 32'd8;
            bus.RegTarget = $urandom() & 32'hFFFF_FFFC;

            mPulse = 1'b0;
            if (!mHalted) begin
                if (mAwaitingFetch) begin
                    if (bus.iHit) begin
                        mInstr = bus.iload;
                        mAwaitingFetch = 1'b0;
                    end
                end else if (bus.Halt) begin
                    mHalted = 1'b1;
                end else if (!(bus.dMemRe || bus.dMemWr) || bus.dHit) begin
                    mPc = modelNext(mPc, mInstr, bus.JReg, bus.JType, bus.PcSrc,
                                    bus.ImmExt, bus.RegTarget);
                    mAwaitingFetch = 1'b1;
                    mPulse = 1'b1;
                    mCount = mCount + 32'd1;
                end
            end
            if (mHalted) haltedFor++;

            step();
            checkOutputs($sformatf("rand%0d", cyc), mPc, mAwaitingFetch && !mHalted,
                         mPulse, mHalted, mInstr);
`ifdef FETCH_INSTR_COUNT_EN
            check($sformatf("rand%0d.InstrCount", cyc), bus.InstrCount, mCount);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
